decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be at least 32.
REQ-002 Parameter REG_ADDR, default 5, register index width; register count is 2**REG_ADDR; SHALL be at least 5.
REQ-003 Ports SHALL be exactly as follows, clock and reset first:
clk  in  1  rising-edge clock; one clock only.
rst  in  1  asynchronous active-high reset.
valid_D  in  1  instr_D/pc_D hold a real instruction.
instr_D  in  32  instruction in the D stage.
pc_D  in  WIDTH  PC of instr_D.
flush_E  in  1  branch/jump taken; kill D->E transfer this cycle.
regWrite_W  in  1  writeback enable.
Rd_W  in  REG_ADDR  writeback destination.
result_W  in  WIDTH  writeback data.
stall_D  out  1  combinational; fetch/D registers must hold.
valid_E, regWrite_E, memWrite_E, jump_E, branch_E, ALUsrc_E, illegal_E  out  1 each  registered E-stage controls.
resultSrc_E  out  2  00 ALU, 01 memory, 10 PC+4.
funct3_E  out  3  instr funct3 (branch/load/store type).
ALUctrl_E  out  4  ALU operation.
Rs1_E, Rs2_E, Rd_E  out  REG_ADDR  register indices (upper bits zero-extended from instr fields).
RD1_E, RD2_E, ImmExt_E, pc_E  out  WIDTH  operands, sign-extended immediate, PC.
a0  out  WIDTH  live value of register 10.
stall_cnt  out  16  count of stall cycles since reset.

Function
REQ-004 Register file: 2**REG_ADDR x WIDTH; register 0 SHALL read zero and ignore writes; write on clk rising edge when regWrite_W.
REQ-005 Reads SHALL be write-through: if regWrite_W and Rd_W==rs (rs!=0), the read returns result_W in the same cycle.
REQ-006 Decode SHALL cover opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI; any other opcode SHALL set illegal, with regWrite/memWrite/jump/branch all 0.
REQ-007 ALUctrl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 pass-B; SUB/SRA chosen by instr[30] (SUB only for R-type); load/store/JALR use ADD; branch uses SUB; LUI uses pass-B.
REQ-008 Immediates: I, S, B, J, U formats per RV32I, sign-extended from instr[31] to WIDTH; U = instr[31:12]<<12, sign-extended.
REQ-009 ALUsrc=1 for I-ALU, load, store, JALR, LUI; resultSrc=01 for load, 10 for JAL/JALR, else 00; regWrite=1 for R, I-ALU, load, JAL, JALR, LUI.
REQ-010 Load-use hazard: stall_D SHALL be 1 when valid_D, valid_E, resultSrc_E==01, Rd_E!=0, and Rd_E equals the used rs1 (all but JAL/LUI) or used rs2 (R, store, branch).
REQ-011 Pipeline register update each rising clk: if flush_E or stall_D, load a bubble (valid_E=0, all control bits 0, data fields don't-care); else load decoded D-stage values with valid_E=valid_D; controls SHALL be 0 when valid_D=0.
REQ-012 flush_E and stall_D together SHALL produce a single bubble; stall_D is not gated by flush_E.
REQ-013 stall_cnt SHALL increment once per cycle with stall_D=1 and saturate at 0xFFFF.
REQ-014 Latency: D-stage inputs appear on E outputs exactly one cycle later.

Reset
REQ-015 While rst=1, all E-stage outputs and stall_cnt SHALL be 0 asynchronously; register file contents SHALL be cleared to 0.
REQ-016 Reset asserted mid-stall SHALL clear valid_E, which removes the stall condition immediately.

Verification
REQ-017 Writeback x5=0x1234 with regWrite_W=1, instr "add x6,x5,x0" in D the same cycle -> next cycle RD1_E=0x1234 (write-through).
REQ-018 "lw x7,0(x1)" then "add x8,x7,x7" -> stall_D=1 for one cycle, bubble valid_E=0, add issues next cycle, stall_cnt=1.
REQ-019 "lw x0,0(x1)" then "add x8,x0,x0" -> no stall.
REQ-020 flush_E=1 with valid "addi x1,x0,-1" in D -> valid_E=0, regWrite_E=0; without flush -> ImmExt_E=all ones, ALUctrl_E=0000, ALUsrc_E=1.
REQ-021 Opcode 0000000 with valid_D=1 -> illegal_E=1, regWrite_E=0, memWrite_E=0.
REQ-022 Write x0=0xFF -> reading x0 returns 0; a0 tracks writes to x10.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode stage with register file, load-use hazard detection and the D->E pipeline register.
module decode_pipe #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_D,
  input  logic [31:0]         instr_D,
  input  logic [WIDTH-1:0]    pc_D,
  input  logic                flush_E,
  input  logic                regWrite_W,
  input  logic [REG_ADDR-1:0] Rd_W,
  input  logic [WIDTH-1:0]    result_W,
  output logic                stall_D,
  output logic                valid_E,
  output logic                regWrite_E,
  output logic                memWrite_E,
  output logic                jump_E,
  output logic                branch_E,
  output logic                ALUsrc_E,
  output logic                illegal_E,
  output logic [1:0]          resultSrc_E,
  output logic [2:0]          funct3_E,
  output logic [3:0]          ALUctrl_E,
  output logic [REG_ADDR-1:0] Rs1_E,
  output logic [REG_ADDR-1:0] Rs2_E,
  output logic [REG_ADDR-1:0] Rd_E,
  output logic [WIDTH-1:0]    RD1_E,
  output logic [WIDTH-1:0]    RD2_E,
  output logic [WIDTH-1:0]    ImmExt_E,
  output logic [WIDTH-1:0]    pc_E,
  output logic [WIDTH-1:0]    a0,
  output logic [15:0]         stall_cnt
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  // funct3 -> ALU op; instr[30] selects SUB only for R-type, SRA for both.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b30,
                                        input logic is_r);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = (is_r && b30) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = b30 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [WIDTH-1:0] regs_q [NumRegs];
  logic [WIDTH-1:0] regs_d [NumRegs];

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [REG_ADDR-1:0] rs1, rs2, rd;
  logic [WIDTH-1:0]    rd1, rd2;
  logic [31:0]         imm32;
  logic                reg_write, mem_write, jump, branch, alu_src, illegal;
  logic [1:0]          result_src;
  logic [3:0]          alu_ctrl;
  logic                uses_rs1, uses_rs2, bubble;

  logic                valid_e_q, valid_e_d;
  logic                reg_write_e_q, reg_write_e_d;
  logic                mem_write_e_q, mem_write_e_d;
  logic                jump_e_q, jump_e_d;
  logic                branch_e_q, branch_e_d;
  logic                alu_src_e_q, alu_src_e_d;
  logic                illegal_e_q, illegal_e_d;
  logic [1:0]          result_src_e_q, result_src_e_d;
  logic [2:0]          funct3_e_q, funct3_e_d;
  logic [3:0]          alu_ctrl_e_q, alu_ctrl_e_d;
  logic [REG_ADDR-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
  logic [WIDTH-1:0]    rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d;
  logic [WIDTH-1:0]    imm_e_q, imm_e_d, pc_e_q, pc_e_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  assign opcode = instr_D[6:0];
  assign funct3 = instr_D[14:12];
  assign rs1    = REG_ADDR'(instr_D[19:15]);
  assign rs2    = REG_ADDR'(instr_D[24:20]);
  assign rd     = REG_ADDR'(instr_D[11:7]);

  // Register file next state; x0 is never written.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) regs_d[i] = regs_q[i];
    if (regWrite_W && (Rd_W != '0)) regs_d[Rd_W] = result_W;
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Write-through reads so the W-stage value is seen in the same cycle.
  always_comb begin
    rd1 = regs_q[rs1];
    rd2 = regs_q[rs2];
    if (rs1 == '0) rd1 = '0;
    else if (regWrite_W && (Rd_W == rs1)) rd1 = result_W;
    if (rs2 == '0) rd2 = '0;
    else if (regWrite_W && (Rd_W == rs2)) rd2 = result_W;
  end

  // Instruction decode: controls, ALU op and immediate.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_ctrl   = AluAdd;
    imm32      = '0;
    case (opcode)
      OpR: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_op(funct3, instr_D[30], 1'b1);
      end
      OpI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = alu_op(funct3, instr_D[30], 1'b0);
        imm32     = {{20{instr_D[31]}}, instr_D[31:20]};
      end
      OpLoad: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm32      = {{20{instr_D[31]}}, instr_D[31:20]};
      end
      OpStore: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm32     = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
      end
      OpBranch: begin
        branch   = 1'b1;
        alu_ctrl = AluSub;
        imm32    = {{19{instr_D[31]}}, instr_D[31], instr_D[7], instr_D[30:25],
                    instr_D[11:8], 1'b0};
      end
      OpJal: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        imm32      = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12], instr_D[20],
                      instr_D[30:21], 1'b0};
      end
      OpJalr: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b10;
        imm32      = {{20{instr_D[31]}}, instr_D[31:20]};
      end
      OpLui: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = AluPassB;
        imm32     = {instr_D[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (!valid_D) begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      jump       = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      illegal    = 1'b0;
      result_src = 2'b00;
      alu_ctrl   = AluAdd;
    end
  end

  // Load-use hazard against the load currently in E.
  always_comb begin
    uses_rs1 = (opcode != OpJal) && (opcode != OpLui);
    uses_rs2 = (opcode == OpR) || (opcode == OpStore) || (opcode == OpBranch);
    stall_D  = valid_D && valid_e_q && (result_src_e_q == 2'b01) && (rd_e_q != '0) &&
               ((uses_rs1 && (rd_e_q == rs1)) || (uses_rs2 && (rd_e_q == rs2)));
  end

  // Pipeline register next state; flush or stall (or both) inserts one bubble.
  always_comb begin
    bubble         = flush_E || stall_D;
    valid_e_d      = bubble ? 1'b0 : valid_D;
    reg_write_e_d  = bubble ? 1'b0 : reg_write;
    mem_write_e_d  = bubble ? 1'b0 : mem_write;
    jump_e_d       = bubble ? 1'b0 : jump;
    branch_e_d     = bubble ? 1'b0 : branch;
    alu_src_e_d    = bubble ? 1'b0 : alu_src;
    illegal_e_d    = bubble ? 1'b0 : illegal;
    result_src_e_d = bubble ? 2'b00 : result_src;
    alu_ctrl_e_d   = bubble ? AluAdd : alu_ctrl;
    funct3_e_d     = funct3;
    rs1_e_d        = rs1;
    rs2_e_d        = rs2;
    rd_e_d         = rd;
    rd1_e_d        = rd1;
    rd2_e_d        = rd2;
    imm_e_d        = WIDTH'($signed(imm32));
    pc_e_d         = pc_D;
    stall_cnt_d    = stall_cnt_q;
    if (stall_D && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // D->E pipeline register and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e_q      <= 1'b0;
      reg_write_e_q  <= 1'b0;
      mem_write_e_q  <= 1'b0;
      jump_e_q       <= 1'b0;
      branch_e_q     <= 1'b0;
      alu_src_e_q    <= 1'b0;
      illegal_e_q    <= 1'b0;
      result_src_e_q <= 2'b00;
      alu_ctrl_e_q   <= 4'b0000;
      funct3_e_q     <= 3'b000;
      rs1_e_q        <= '0;
      rs2_e_q        <= '0;
      rd_e_q         <= '0;
      rd1_e_q        <= '0;
      rd2_e_q        <= '0;
      imm_e_q        <= '0;
      pc_e_q         <= '0;
      stall_cnt_q    <= '0;
    end else begin
      valid_e_q      <= valid_e_d;
      reg_write_e_q  <= reg_write_e_d;
      mem_write_e_q  <= mem_write_e_d;
      jump_e_q       <= jump_e_d;
      branch_e_q     <= branch_e_d;
      alu_src_e_q    <= alu_src_e_d;
      illegal_e_q    <= illegal_e_d;
      result_src_e_q <= result_src_e_d;
      alu_ctrl_e_q   <= alu_ctrl_e_d;
      funct3_e_q     <= funct3_e_d;
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      rd1_e_q        <= rd1_e_d;
      rd2_e_q        <= rd2_e_d;
      imm_e_q        <= imm_e_d;
      pc_e_q         <= pc_e_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign valid_E     = valid_e_q;
  assign regWrite_E  = reg_write_e_q;
  assign memWrite_E  = mem_write_e_q;
  assign jump_E      = jump_e_q;
  assign branch_E    = branch_e_q;
  assign ALUsrc_E    = alu_src_e_q;
  assign illegal_E   = illegal_e_q;
  assign resultSrc_E = result_src_e_q;
  assign funct3_E    = funct3_e_q;
  assign ALUctrl_E   = alu_ctrl_e_q;
  assign Rs1_E       = rs1_e_q;
  assign Rs2_E       = rs2_e_q;
  assign Rd_E        = rd_e_q;
  assign RD1_E       = rd1_e_q;
  assign RD2_E       = rd2_e_q;
  assign ImmExt_E    = imm_e_q;
  assign pc_E        = pc_e_q;
  assign a0          = regs_q[10];
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode table plus hazard, flush and reset sequences.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_D;
  logic [31:0] instr_D, pc_D;
  logic        flush_E, regWrite_W;
  logic [4:0]  Rd_W;
  logic [31:0] result_W;
  logic        stall_D, valid_E, regWrite_E, memWrite_E, jump_E, branch_E, ALUsrc_E, illegal_E;
  logic [1:0]  resultSrc_E;
  logic [2:0]  funct3_E;
  logic [3:0]  ALUctrl_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, pc_E, a0;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  decode_pipe #(.WIDTH(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
    .flush_E(flush_E), .regWrite_W(regWrite_W), .Rd_W(Rd_W), .result_W(result_W),
    .stall_D(stall_D), .valid_E(valid_E), .regWrite_E(regWrite_E), .memWrite_E(memWrite_E),
    .jump_E(jump_E), .branch_E(branch_E), .ALUsrc_E(ALUsrc_E), .illegal_E(illegal_E),
    .resultSrc_E(resultSrc_E), .funct3_E(funct3_E), .ALUctrl_E(ALUctrl_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .ImmExt_E(ImmExt_E), .pc_E(pc_E), .a0(a0), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {valid, regWrite, memWrite, jump, branch, ALUsrc, illegal, resultSrc, ALUctrl}
  function automatic logic [12:0] ctrl_word();
    return {valid_E, regWrite_E, memWrite_E, jump_E, branch_E, ALUsrc_E, illegal_E,
            resultSrc_E, ALUctrl_E};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    valid_D = v;
    instr_D = ins;
    pc_D    = pc_D + 32'd4;
  endtask

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] instr;
    logic [12:0] ctrl;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[13];

  localparam logic [31:0] AddX6X5X0 = 32'h0002_8333;
  localparam logic [31:0] LwX7      = 32'h0000_A383;
  localparam logic [31:0] AddX8X7X7 = 32'h0073_8433;
  localparam logic [31:0] LwX0      = 32'h0000_A003;
  localparam logic [31:0] AddX8X0X0 = 32'h0000_0433;
  localparam logic [31:0] AddiM1    = 32'hFFF0_0093;

  initial begin
    vecs[0]  = '{"add",   1'b1, AddX6X5X0,    13'b1_1000_0_0_00_0000, 32'h0};
    vecs[1]  = '{"sub",   1'b1, 32'h402081B3, 13'b1_1000_0_0_00_0001, 32'h0};
    vecs[2]  = '{"xor",   1'b1, 32'h0020C4B3, 13'b1_1000_0_0_00_0100, 32'h0};
    vecs[3]  = '{"addi",  1'b1, AddiM1,       13'b1_1000_1_0_00_0000, 32'hFFFF_FFFF};
    vecs[4]  = '{"srai",  1'b1, 32'h4030D213, 13'b1_1000_1_0_00_0111, 32'h0000_0403};
    vecs[5]  = '{"lw",    1'b1, LwX7,         13'b1_1000_1_0_01_0000, 32'h0};
    vecs[6]  = '{"jal",   1'b1, 32'h008000EF, 13'b1_1010_0_0_10_0000, 32'h8};
    vecs[7]  = '{"sw",    1'b1, 32'h0020A423, 13'b1_0100_1_0_00_0000, 32'h8};
    vecs[8]  = '{"beq",   1'b1, 32'hFE208EE3, 13'b1_0001_0_0_00_0001, 32'hFFFF_FFFC};
    vecs[9]  = '{"jalr",  1'b1, 32'h00408067, 13'b1_1010_1_0_10_0000, 32'h4};
    vecs[10] = '{"lui",   1'b1, 32'h800002B7, 13'b1_1000_1_0_00_1010, 32'h8000_0000};
    vecs[11] = '{"ill",   1'b1, 32'h0000_0000, 13'b1_0000_0_1_00_0000, 32'h0};
    vecs[12] = '{"nvalid", 1'b0, AddX6X5X0,   13'b0_0000_0_0_00_0000, 32'h0};

    rst = 1'b1; valid_D = 1'b0; instr_D = '0; pc_D = 32'h100; flush_E = 1'b0;
    regWrite_W = 1'b0; Rd_W = '0; result_W = '0;
    #12;
    chk("rst_ctrl", 32'(ctrl_word()), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_pc_E", pc_E, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write-through of x5 into the add issued the same cycle.
    drive(1'b1, AddX6X5X0);
    regWrite_W = 1'b1; Rd_W = 5'd5; result_W = 32'h1234;
    tick();
    chk("wt_RD1", RD1_E, 32'h1234);
    chk("wt_Rd", 32'(Rd_E), 32'd6);
    chk("wt_pc", pc_E, pc_D);

    // x0 ignores writes, both via write-through and afterwards.
    drive(1'b1, AddX8X0X0);
    Rd_W = 5'd0; result_W = 32'hFF;
    tick();
    chk("x0_wt_RD1", RD1_E, 32'h0);
    regWrite_W = 1'b0;
    tick();
    chk("x0_RD2", RD2_E, 32'h0);

    // a0 follows x10.
    drive(1'b0, 32'h0);
    regWrite_W = 1'b1; Rd_W = 5'd10; result_W = 32'hCAFE;
    tick();
    regWrite_W = 1'b0;
    chk("a0", a0, 32'hCAFE);

    // Load-use: one stall cycle, one bubble, then the add issues.
    drive(1'b1, LwX7);
    tick();
    drive(1'b1, AddX8X7X7);
    #1 chk("lu_stall", 32'(stall_D), 32'd1);
    tick();
    chk("lu_bubble", 32'(valid_E), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_stall_gone", 32'(stall_D), 32'd0);
    tick();
    chk("lu_issue_v", 32'(valid_E), 32'd1);
    chk("lu_issue_rd", 32'(Rd_E), 32'd8);
    chk("lu_issue_rs1", 32'(Rs1_E), 32'd7);

    // Load to x0 never stalls.
    drive(1'b1, LwX0);
    tick();
    drive(1'b1, AddX8X0X0);
    #1 chk("lw_x0_stall", 32'(stall_D), 32'd0);
    tick();
    chk("lw_x0_v", 32'(valid_E), 32'd1);
    chk("lw_x0_cnt", 32'(stall_cnt), 32'd1);

    // Flush kills the transfer; without flush the addi decodes.
    drive(1'b1, AddiM1);
    flush_E = 1'b1;
    tick();
    chk("flush_v", 32'(valid_E), 32'd0);
    chk("flush_rw", 32'(regWrite_E), 32'd0);
    flush_E = 1'b0;
    tick();
    chk("addi_imm", ImmExt_E, 32'hFFFF_FFFF);
    chk("addi_alu", 32'(ALUctrl_E), 32'd0);
    chk("addi_src", 32'(ALUsrc_E), 32'd1);

    // Flush together with stall: stall still visible, single bubble, counted.
    drive(1'b1, LwX7);
    tick();
    drive(1'b1, AddX8X7X7);
    flush_E = 1'b1;
    #1 chk("fs_stall", 32'(stall_D), 32'd1);
    tick();
    flush_E = 1'b0;
    chk("fs_v", 32'(valid_E), 32'd0);
    chk("fs_cnt", 32'(stall_cnt), 32'd2);

    // Decode table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].instr);
      tick();
      chk({vecs[i].name, "_ctrl"}, 32'(ctrl_word()), 32'(vecs[i].ctrl));
      chk({vecs[i].name, "_imm"}, ImmExt_E, vecs[i].imm);
    end

    // Reset asserted mid-stall drops valid_E and the stall immediately.
    drive(1'b1, LwX7);
    tick();
    drive(1'b1, AddX8X7X7);
    #1 chk("rs_stall_pre", 32'(stall_D), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_stall", 32'(stall_D), 32'd0);
    chk("rs_v", 32'(valid_E), 32'd0);
    chk("rs_cnt", 32'(stall_cnt), 32'd0);
    chk("rs_a0", a0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
